// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetches 16-bit instructions, drives the register file and ALU select,
// and resolves jumps from the ALU compare flag. Define CU_HALT_EN to make 0xFFFF a halt.
module control_unit #(
    parameter int unsigned PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [3:0]      rf_raddr_a,
    output logic [3:0]      rf_raddr_b,
    output logic [3:0]      rf_waddr,
    output logic            rf_we,
    output logic            b_imm_sel,
    output logic [7:0]      imm,
    output logic [3:0]      alu_sel,
    input  logic            alu_cmp,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam logic [3:0] OP_LDI = 4'hE;
    localparam logic [3:0] OP_JMP = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE
`ifdef CU_HALT_EN
        , S_HALT
`endif
    } state_t;

    state_t          state;
    logic [15:0]     ir;
    logic [15:0]     dec_word;
    logic [3:0]      dec_op;
    logic [3:0]      dec_alu_sel;
    logic [3:0]      dec_ra;
    logic            dec_bimm;
    logic [3:0]      ir_op;
    logic            ir_write;
    logic            ir_cond;
    logic [PC_W-1:0] pc_next;

    assign imem_addr = pc;

    // Decode the word being latched while fetching, and the held IR afterwards
    assign dec_word = (state == S_FETCH) ? imem_data : ir;
    assign dec_op   = dec_word[15:12];

    always_comb begin
        dec_alu_sel = dec_op;
        dec_ra      = dec_word[7:4];
        dec_bimm    = 1'b0;
        if (dec_op inside {[4'hA:4'hD]}) begin
            dec_ra = dec_word[11:8];
        end else if (dec_op == OP_LDI) begin
            dec_alu_sel = 4'h0;
            dec_bimm    = 1'b1;
        end
    end

    assign ir_op    = ir[15:12];
    assign ir_write = (ir_op <= 4'h9) || (ir_op == OP_LDI);
    assign ir_cond  = ir_op inside {[4'hA:4'hD]};

    always_comb begin
        pc_next = pc + PC_W'(1);
        if ((ir_op == OP_JMP) || (ir_cond && alu_cmp)) begin
            pc_next = PC_W'(ir[7:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            imem_req   <= 1'b0;
            rf_raddr_a <= '0;
            rf_raddr_b <= '0;
            rf_waddr   <= '0;
            rf_we      <= 1'b0;
            b_imm_sel  <= 1'b0;
            imm        <= '0;
            alu_sel    <= '0;
`ifdef CU_HALT_EN
            halted     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir         <= imem_data;
                        imem_req   <= 1'b0;
                        rf_raddr_a <= dec_ra;
                        rf_raddr_b <= dec_word[3:0];
                        rf_waddr   <= dec_word[11:8];
                        imm        <= dec_word[7:0];
                        alu_sel    <= dec_alu_sel;
                        b_imm_sel  <= dec_bimm;
                        state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rf_raddr_a <= dec_ra;
                    rf_raddr_b <= dec_word[3:0];
                    rf_waddr   <= dec_word[11:8];
                    imm        <= dec_word[7:0];
                    alu_sel    <= dec_alu_sel;
                    b_imm_sel  <= dec_bimm;
                    rf_we      <= ir_write;
                    state      <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    rf_we     <= 1'b0;
                    alu_sel   <= '0;
                    b_imm_sel <= 1'b0;
`ifdef CU_HALT_EN
                    if (ir == 16'hFFFF) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        pc       <= pc_next;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
`else
                    pc       <= pc_next;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
`endif
                end
`ifdef CU_HALT_EN
                S_HALT: begin
                    state <= S_HALT;
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef CU_HALT_EN
    assign halted = 1'b0;
`endif

endmodule
